// File: rtl/energy_step_scheduler.sv
// energy_step_scheduler
// Run-level controller for the energy monitor spin-index datapath. Takes a
// per-run spin count, clears the accumulator, streams spin-index beats in
// strides of PARALLELISM, waits out the datapath latency and pulses done.
// Optional feature macro: ENERGY_SCHED_CYCLE_CNT_EN adds a 32-bit run-cycle
// counter on cycle_cnt_o.
module energy_step_scheduler #(
    parameter int COUNTER_BITWIDTH = 8,
    parameter int PARALLELISM      = 4,
    parameter int PIPE_LATENCY     = 2
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        cfg_valid_i,
    output logic                        cfg_ready_o,
    input  logic [COUNTER_BITWIDTH:0]   cfg_num_spins_i,
    input  logic                        start_i,
    input  logic                        abort_i,
    output logic                        busy_o,
    output logic                        acc_clear_o,
    output logic                        idx_valid_o,
    input  logic                        idx_ready_i,
    output logic [COUNTER_BITWIDTH-1:0] idx_o,
    output logic                        idx_last_o,
    output logic                        done_o
`ifdef ENERGY_SCHED_CYCLE_CNT_EN
    ,
    output logic [31:0]                 cycle_cnt_o
`endif
);

    localparam int CW = COUNTER_BITWIDTH;
    localparam int DW = (PIPE_LATENCY > 1) ? $clog2(PIPE_LATENCY) : 1;

    localparam logic [CW:0]   NUM_RESET  = {1'b1, {CW{1'b0}}};
    localparam logic [CW-1:0] IDX_STEP   = CW'(PARALLELISM);
    localparam logic [CW:0]   IDX_STEP_X = (CW+1)'(PARALLELISM);
    localparam logic [DW-1:0] DRAIN_LOAD = DW'((PIPE_LATENCY > 0) ? PIPE_LATENCY - 1 : 0);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        ISSUE = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_e;

    state_e          state_q;
    logic [CW:0]     num_spins_q;
    logic [CW-1:0]   idx_q;
    logic [DW-1:0]   drain_q;
    logic            last_beat;

    // Final beat when this beat's stride reaches the run length; the extra
    // top bit keeps the sum from wrapping at the end of the index range.
    assign last_beat = ({1'b0, idx_q} + IDX_STEP_X) >= num_spins_q;

    // Every output is a decode of registered state, so idx_ready_i never
    // reaches idx_valid_o combinationally.
    always_comb begin
        cfg_ready_o = (state_q == IDLE);
        busy_o      = (state_q != IDLE);
        acc_clear_o = (state_q == CLEAR);
        idx_valid_o = (state_q == ISSUE);
        idx_last_o  = (state_q == ISSUE) && last_beat;
        done_o      = (state_q == DONE);
        idx_o       = idx_q;
    end

    // Run FSM together with its spin-count, index and drain registers.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            num_spins_q <= NUM_RESET;
            idx_q       <= '0;
            drain_q     <= '0;
        end else begin
            // Config lands in the same edge as start, so the run sees it.
            if (state_q == IDLE && cfg_valid_i) begin
                num_spins_q <= cfg_num_spins_i;
            end

            if (abort_i && state_q != IDLE) begin
                state_q <= IDLE;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (start_i) begin
                            state_q <= CLEAR;
                            idx_q   <= '0;
                        end
                    end
                    CLEAR: begin
                        state_q <= (num_spins_q == '0) ? DONE : ISSUE;
                    end
                    ISSUE: begin
                        if (idx_ready_i) begin
                            if (last_beat) begin
                                // Index keeps the final beat value until the next CLEAR.
                                if (PIPE_LATENCY == 0) begin
                                    state_q <= DONE;
                                end else begin
                                    state_q <= DRAIN;
                                    drain_q <= DRAIN_LOAD;
                                end
                            end else begin
                                idx_q <= idx_q + IDX_STEP;
                            end
                        end
                    end
                    DRAIN: begin
                        if (drain_q == '0) begin
                            state_q <= DONE;
                        end else begin
                            drain_q <= drain_q - 1'b1;
                        end
                    end
                    DONE: begin
                        state_q <= IDLE;
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

`ifdef ENERGY_SCHED_CYCLE_CNT_EN
    logic [31:0] cycle_cnt_q;

    // Saturating count of ISSUE/DRAIN/DONE cycles, frozen by abort.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cycle_cnt_q <= '0;
        end else if (state_q == IDLE) begin
            if (start_i) begin
                cycle_cnt_q <= '0;
            end
        end else if (!abort_i && state_q != CLEAR && cycle_cnt_q != '1) begin
            cycle_cnt_q <= cycle_cnt_q + 32'd1;
        end
    end

    assign cycle_cnt_o = cycle_cnt_q;
`endif

endmodule

// File: tb/tb_energy_step_scheduler.sv
// Directed testbench for energy_step_scheduler (default parameters:
// COUNTER_BITWIDTH=8, PARALLELISM=4, PIPE_LATENCY=2).
module tb_energy_step_scheduler;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       cfg_valid_i;
    logic       cfg_ready_o;
    logic [8:0] cfg_num_spins_i;
    logic       start_i;
    logic       abort_i;
    logic       busy_o;
    logic       acc_clear_o;
    logic       idx_valid_o;
    logic       idx_ready_i;
    logic [7:0] idx_o;
    logic       idx_last_o;
    logic       done_o;
`ifdef ENERGY_SCHED_CYCLE_CNT_EN
    logic [31:0] cycle_cnt_o;
`endif

    int tests = 0;
    int fails = 0;

    energy_step_scheduler dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .cfg_valid_i     (cfg_valid_i),
        .cfg_ready_o     (cfg_ready_o),
        .cfg_num_spins_i (cfg_num_spins_i),
        .start_i         (start_i),
        .abort_i         (abort_i),
        .busy_o          (busy_o),
        .acc_clear_o     (acc_clear_o),
        .idx_valid_o     (idx_valid_o),
        .idx_ready_i     (idx_ready_i),
        .idx_o           (idx_o),
        .idx_last_o      (idx_last_o),
        .done_o          (done_o)
`ifdef ENERGY_SCHED_CYCLE_CNT_EN
        ,
        .cycle_cnt_o     (cycle_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    // Advance one clock and settle just after the edge before sampling.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Reset values, then a run on the reset spin count (256 -> 64 beats).
    task automatic test_reset();
        int beats;
        int dones;
        rst_ni          = 1'b0;
        cfg_valid_i     = 1'b0;
        cfg_num_spins_i = '0;
        start_i         = 1'b0;
        abort_i         = 1'b0;
        idx_ready_i     = 1'b1;
        #12;
        tests++;
        if ({busy_o, acc_clear_o, idx_valid_o, idx_last_o, done_o, cfg_ready_o} !== 6'b000001 || idx_o !== 8'd0) begin
            fails++;
            $display("FAIL reset_in flags=%b idx=%0d, want 000001 idx=0",
                     {busy_o, acc_clear_o, idx_valid_o, idx_last_o, done_o, cfg_ready_o}, idx_o);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();
        tests++;
        if ({busy_o, acc_clear_o, idx_valid_o, idx_last_o, done_o, cfg_ready_o} !== 6'b000001 || idx_o !== 8'd0) begin
            fails++;
            $display("FAIL reset_out flags=%b idx=%0d, want 000001 idx=0",
                     {busy_o, acc_clear_o, idx_valid_o, idx_last_o, done_o, cfg_ready_o}, idx_o);
        end
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        tests++;
        if (acc_clear_o !== 1'b1 || idx_valid_o !== 1'b0) begin
            fails++;
            $display("FAIL reset_run_clear clear=%b valid=%b, want 1 0", acc_clear_o, idx_valid_o);
        end
        beats = 0;
        dones = 0;
        for (int c = 0; c < 100 && busy_o; c++) begin
            tick();
            if (idx_valid_o) begin
                tests++;
                if (idx_o !== 8'(beats * 4) || idx_last_o !== (beats == 63)) begin
                    fails++;
                    $display("FAIL reset_run_beat%0d idx=%0d last=%b, want idx=%0d last=%b",
                             beats, idx_o, idx_last_o, beats * 4, (beats == 63));
                end
                beats++;
            end
            if (done_o) dones++;
        end
        tests++;
        if (busy_o !== 1'b0 || beats != 64 || dones != 1 || idx_o !== 8'd252) begin
            fails++;
            $display("FAIL reset_run_end busy=%b beats=%0d dones=%0d idx=%0d, want 0 64 1 252",
                     busy_o, beats, dones, idx_o);
        end
    endtask

    // cfg 16 with start in the same cycle; exact cycle-by-cycle timeline.
    task automatic test_basic16();
        // {acc_clear, valid, last, done, busy} for cycles 1..9
        logic [4:0] exp_flags [1:9];
        logic [7:0] exp_idx   [1:9];
        exp_flags = '{5'b10001, 5'b01001, 5'b01001, 5'b01001, 5'b01101,
                      5'b00001, 5'b00001, 5'b00011, 5'b00000};
        exp_idx   = '{8'd0, 8'd0, 8'd4, 8'd8, 8'd12, 8'd12, 8'd12, 8'd12, 8'd12};
        idx_ready_i     = 1'b1;
        cfg_valid_i     = 1'b1;
        cfg_num_spins_i = 9'd16;
        start_i         = 1'b1;
        tick();
        cfg_valid_i = 1'b0;
        start_i     = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            tests++;
            if ({acc_clear_o, idx_valid_o, idx_last_o, done_o, busy_o} !== exp_flags[c] ||
                idx_o !== exp_idx[c] || cfg_ready_o !== ~exp_flags[c][0]) begin
                fails++;
                $display("FAIL basic16_cyc%0d flags=%b idx=%0d rdy=%b, want %b idx=%0d rdy=%b",
                         c, {acc_clear_o, idx_valid_o, idx_last_o, done_o, busy_o}, idx_o,
                         cfg_ready_o, exp_flags[c], exp_idx[c], ~exp_flags[c][0]);
            end
            if (c != 9) tick();
        end
    endtask

    // cfg 10: partial final beat, three transfers 0,4,8 with last on 8.
    task automatic test_partial10();
        int beats;
        int dones;
        idx_ready_i     = 1'b1;
        cfg_valid_i     = 1'b1;
        cfg_num_spins_i = 9'd10;
        tick();
        cfg_valid_i = 1'b0;
        start_i     = 1'b1;
        tick();
        start_i = 1'b0;
        beats = 0;
        dones = 0;
        for (int c = 0; c < 30 && busy_o; c++) begin
            tick();
            if (idx_valid_o) begin
                tests++;
                if (idx_o !== 8'(beats * 4) || idx_last_o !== (beats == 2)) begin
                    fails++;
                    $display("FAIL partial10_beat%0d idx=%0d last=%b, want idx=%0d last=%b",
                             beats, idx_o, idx_last_o, beats * 4, (beats == 2));
                end
                beats++;
            end
            if (done_o) dones++;
        end
        tests++;
        if (busy_o !== 1'b0 || beats != 3 || dones != 1) begin
            fails++;
            $display("FAIL partial10_end busy=%b beats=%0d dones=%0d, want 0 3 1", busy_o, beats, dones);
        end
    endtask

    // Ready low for three cycles on idx 4 of a 16-spin run; done moves 8 -> 11.
    task automatic test_backpressure();
        int done_cyc;
        int cyc;
        idx_ready_i     = 1'b1;
        cfg_valid_i     = 1'b1;
        cfg_num_spins_i = 9'd16;
        start_i         = 1'b1;
        tick();                 // cycle 1: CLEAR
        cfg_valid_i = 1'b0;
        start_i     = 1'b0;
        tick();                 // cycle 2: idx 0
        tick();                 // cycle 3: idx 4
        idx_ready_i = 1'b0;
        for (int s = 0; s < 4; s++) begin
            if (s == 3) idx_ready_i = 1'b1;
            tests++;
            if (idx_o !== 8'd4 || idx_valid_o !== 1'b1 || idx_last_o !== 1'b0) begin
                fails++;
                $display("FAIL backpressure_hold%0d idx=%0d valid=%b last=%b, want 4 1 0",
                         s, idx_o, idx_valid_o, idx_last_o);
            end
            if (s != 3) tick();
        end
        cyc      = 6;
        done_cyc = -1;
        for (int c = 0; c < 20 && busy_o; c++) begin
            tick();
            cyc++;
            if (done_o) done_cyc = cyc;
        end
        tests++;
        if (done_cyc != 11 || busy_o !== 1'b0) begin
            fails++;
            $display("FAIL backpressure_done done_cycle=%0d busy=%b, want 11 0", done_cyc, busy_o);
        end
    endtask

    // cfg 0 goes CLEAR -> DONE; config offered while busy is refused.
    task automatic test_zero_and_busy_cfg();
        idx_ready_i     = 1'b1;
        cfg_valid_i     = 1'b1;
        cfg_num_spins_i = 9'd0;
        start_i         = 1'b1;
        tick();                 // cycle 1: CLEAR
        start_i         = 1'b0;
        cfg_num_spins_i = 9'd5; // offered while busy
        tests++;
        if (acc_clear_o !== 1'b1 || idx_valid_o !== 1'b0 || cfg_ready_o !== 1'b0) begin
            fails++;
            $display("FAIL zero_clear clear=%b valid=%b rdy=%b, want 1 0 0", acc_clear_o, idx_valid_o, cfg_ready_o);
        end
        tick();                 // cycle 2: DONE
        cfg_valid_i = 1'b0;
        tests++;
        if (done_o !== 1'b1 || idx_valid_o !== 1'b0 || acc_clear_o !== 1'b0) begin
            fails++;
            $display("FAIL zero_done done=%b valid=%b clear=%b, want 1 0 0", done_o, idx_valid_o, acc_clear_o);
        end
        tick();
        tests++;
        if (busy_o !== 1'b0 || done_o !== 1'b0) begin
            fails++;
            $display("FAIL zero_idle busy=%b done=%b, want 0 0", busy_o, done_o);
        end
        // Restart without config: the refused 5 must not have landed.
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick();
        tests++;
        if (done_o !== 1'b1 || idx_valid_o !== 1'b0) begin
            fails++;
            $display("FAIL busy_cfg_refused done=%b valid=%b, want 1 0", done_o, idx_valid_o);
        end
        tick();
    endtask

    // Abort at idx 8 of a 32-spin run, then restart (abort in IDLE ignored).
    task automatic test_abort();
        int beats;
        int dones;
        idx_ready_i     = 1'b1;
        cfg_valid_i     = 1'b1;
        cfg_num_spins_i = 9'd32;
        start_i         = 1'b1;
        tick();                 // CLEAR
        cfg_valid_i = 1'b0;
        start_i     = 1'b0;
        tick();                 // idx 0
        tick();                 // idx 4
        tick();                 // idx 8
        tests++;
        if (idx_o !== 8'd8 || idx_valid_o !== 1'b1) begin
            fails++;
            $display("FAIL abort_pre idx=%0d valid=%b, want 8 1", idx_o, idx_valid_o);
        end
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        tests++;
        if ({busy_o, idx_valid_o, done_o, acc_clear_o} !== 4'b0000) begin
            fails++;
            $display("FAIL abort_idle busy/valid/done/clear=%b, want 0000",
                     {busy_o, idx_valid_o, done_o, acc_clear_o});
        end
        tick();
        tests++;
        if (done_o !== 1'b0 || busy_o !== 1'b0) begin
            fails++;
            $display("FAIL abort_no_done done=%b busy=%b, want 0 0", done_o, busy_o);
        end
        abort_i = 1'b1;
        start_i = 1'b1;
        tick();
        abort_i = 1'b0;
        start_i = 1'b0;
        tests++;
        if (acc_clear_o !== 1'b1 || idx_o !== 8'd0 || busy_o !== 1'b1) begin
            fails++;
            $display("FAIL abort_restart clear=%b idx=%0d busy=%b, want 1 0 1", acc_clear_o, idx_o, busy_o);
        end
        beats = 0;
        dones = 0;
        for (int c = 0; c < 40 && busy_o; c++) begin
            tick();
            if (idx_valid_o) begin
                tests++;
                if (idx_o !== 8'(beats * 4) || idx_last_o !== (beats == 7)) begin
                    fails++;
                    $display("FAIL abort_rerun_beat%0d idx=%0d last=%b, want idx=%0d last=%b",
                             beats, idx_o, idx_last_o, beats * 4, (beats == 7));
                end
                beats++;
            end
            if (done_o) dones++;
        end
        tests++;
        if (busy_o !== 1'b0 || beats != 8 || dones != 1) begin
            fails++;
            $display("FAIL abort_rerun_end busy=%b beats=%0d dones=%0d, want 0 8 1", busy_o, beats, dones);
        end
    endtask

    initial begin
        test_reset();
        test_basic16();
        test_partial10();
        test_backpressure();
        test_zero_and_busy_cfg();
        test_abort();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
